tcdm64_rr_arbiter: RTL
======================

Name: tcdm64_rr_arbiter

Overview:
- Shares one 64-bit TCDM slave port (req/add/wen/wdata/be/gnt, r_opc/r_rdata/r_valid) between NB_MASTERS 64-bit TCDM masters.
- Arbitration is fair round-robin with a request lock.
- Responses are routed back to the issuing master in order, using an internal FIFO of master IDs for outstanding transactions.
- Sits between cluster-side 64-bit requesters (DMA, wide cores) and a single 64-bit TCDM bank or xbar port.

Parameters:
NB_MASTERS, 4, number of requesting masters (>=2)
MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO, i.e. max granted-but-unanswered transactions (>=1)
IDW, $clog2(NB_MASTERS), derived master index width (localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  NB_MASTERS  per-master request
add_i  in  NB_MASTERS*32  per-master byte address, master m at [m*32+:32]
wen_i  in  NB_MASTERS  per-master write-enable-low (1=read, 0=write)
wdata_i  in  NB_MASTERS*64  per-master write data
be_i  in  NB_MASTERS*8  per-master byte enables
gnt_o  out  NB_MASTERS  per-master grant
r_rdata_o  out  NB_MASTERS*64  per-master read data
r_opc_o  out  NB_MASTERS  per-master response error/opcode
r_valid_o  out  NB_MASTERS  per-master response valid
slv_req_o  out  1  request to slave
slv_add_o  out  32  address to slave
slv_wen_o  out  1  wen to slave
slv_wdata_o  out  64  write data to slave
slv_be_o  out  8  byte enables to slave
slv_gnt_i  in  1  slave grant
slv_r_rdata_i  in  64  slave read data
slv_r_opc_i  in  1  slave response opcode
slv_r_valid_i  in  1  slave response valid
err_o  out  1  sticky: r_valid received with no outstanding transaction

Behaviour:
- Reset (rst_i=1, asynchronous, active-high): rr_ptr=0, lock cleared, FIFO empty (count=0), err_o=0. All outputs are combinationally 0 while no request is pending.
- Winner selection:
  - If lock is set, winner = locked index.
  - Otherwise winner = first m with req_i[m]=1, scanning rr_ptr, rr_ptr+1, ... modulo NB_MASTERS.
- Stall: stall = (count==MAX_OUTSTANDING). No bypass, even if slv_r_valid_i pops in the same cycle.
- slv_req_o = any req_i && !stall. slv_add/wen/wdata/be_o = winner's fields (mux). They are 0 when slv_req_o=0.
- gnt_o[winner] = slv_gnt_i && slv_req_o. All other gnt_o bits are 0. Grant is same-cycle (combinational), zero added latency on the request path.
- Handshake hs = slv_req_o && slv_gnt_i. On hs:
  - push winner into the ID FIFO;
  - rr_ptr <= (winner+1) mod NB_MASTERS;
  - clear lock.
- Lock: if slv_req_o=1 && slv_gnt_i=0, set lock to winner. Slave-facing fields stay stable until granted. Masters must hold req_i and fields until gnt_o (TCDM rule); dropping req_i while locked is illegal and is not checked.
- Response: on slv_r_valid_i with count>0:
  - pop the FIFO head h;
  - r_valid_o[h]=1, and only bit h.
- r_rdata_o and r_opc_o: slave values broadcast to all masters. Only r_valid_o qualifies them.
- Reads and writes each produce exactly one slv_r_valid_i, in issue order.
- Simultaneous push and pop: count unchanged. Head and tail pointers both advance, modulo MAX_OUTSTANDING.
- slv_r_valid_i with count==0: no r_valid_o asserted, FIFO unchanged, err_o <= 1 and held until reset.
- Reset mid-transaction: all state is cleared immediately. Responses arriving after reset for pre-reset requests count as spurious and set err_o.
- NB_MASTERS not a power of two: the pointer wraps explicitly at NB_MASTERS-1 to 0, never to an unused index.

Test Plan:
- Single master: req_i=4'b0100, add=0x100, wen=1, slv_gnt_i=1 -> gnt_o=4'b0100 in the same cycle, slv_add_o=0x100. Next cycle slv_r_valid_i=1, rdata=0xDEADBEEF_CAFEF00D -> r_valid_o=4'b0100 with that data.
- Fairness: all four masters request continuously, slv_gnt_i=1, response 1 cycle later -> grant order 0,1,2,3,0,... Each r_valid_o returns to the matching master one cycle after its grant.
- Lock: masters 1 and 3 request, rr_ptr=0, slv_gnt_i=0 for 3 cycles, then master 0 raises req -> slv_add_o stays master 1's address throughout, and master 1 is granted first when slv_gnt_i=1.
- Outstanding limit: MAX_OUTSTANDING=2, slave grants every cycle but delays responses -> after 2 handshakes slv_req_o=0 and gnt_o=0. When a response pops, slv_req_o reasserts the following cycle. Responses return in order to masters 0 then 1.
- Spurious response: slv_r_valid_i=1 with FIFO empty -> r_valid_o=0, err_o=1 from the next cycle onward, cleared only by rst_i.
- Async reset during a locked stall: rst_i pulsed mid-cycle -> slv_req_o follows req_i without lock, rr_ptr=0, count=0, err_o=0.

Source files
------------

// File: rtl/tcdm64_rr_arbiter.sv
// tcdm64_rr_arbiter
//   Lets NB_MASTERS 64-bit TCDM masters share one 64-bit TCDM slave port.
//   Masters win in fair round-robin order. A master that is refused a
//   grant keeps the port (request lock) until the slave grants it.
//   The index of every granted master goes into a small in-order FIFO.
//   Each slave response is steered back to the master at the FIFO head.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i/add_i/wen_i/    per-master request bus, master m at slice m
//   wdata_i/be_i
//   gnt_o                 per-master grant, combinational
//   r_rdata_o/r_opc_o     slave response, broadcast to every master
//   r_valid_o             per-master response valid, one-hot
//   slv_*_o               request bus to the slave (all zero when idle)
//   slv_gnt_i             slave grant
//   slv_r_*_i             slave response
//   err_o                 sticky: a response arrived with nothing outstanding
module tcdm64_rr_arbiter #(
  parameter int unsigned NB_MASTERS      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NB_MASTERS-1:0]    req_i,
  input  logic [NB_MASTERS*32-1:0] add_i,
  input  logic [NB_MASTERS-1:0]    wen_i,
  input  logic [NB_MASTERS*64-1:0] wdata_i,
  input  logic [NB_MASTERS*8-1:0]  be_i,
  output logic [NB_MASTERS-1:0]    gnt_o,
  output logic [NB_MASTERS*64-1:0] r_rdata_o,
  output logic [NB_MASTERS-1:0]    r_opc_o,
  output logic [NB_MASTERS-1:0]    r_valid_o,
  output logic                     slv_req_o,
  output logic [31:0]              slv_add_o,
  output logic                     slv_wen_o,
  output logic [63:0]              slv_wdata_o,
  output logic [7:0]               slv_be_o,
  input  logic                     slv_gnt_i,
  input  logic [63:0]              slv_r_rdata_i,
  input  logic                     slv_r_opc_i,
  input  logic                     slv_r_valid_i,
  output logic                     err_o
);

  localparam int unsigned IDW = $clog2(NB_MASTERS);
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    LK_FREE,
    LK_HELD
  } lock_e;

  lock_e          lock_q, lock_d;
  logic [IDW-1:0] lock_idx_q, lock_idx_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] winner;
  logic           found;
  int unsigned    scan_idx;

  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;
  logic           err_q;

  logic stall, hs, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Winner: the locked master if a lock is held, otherwise the first
  // requester found scanning upward from rr_ptr. The scan index wraps
  // explicitly so that non-power-of-two master counts never hit an unused index.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (lock_q == LK_HELD) begin
      winner = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NB_MASTERS; i++) begin
        scan_idx = 32'(rr_ptr_q) + i;
        if (scan_idx >= NB_MASTERS) scan_idx = scan_idx - NB_MASTERS;
        if (!found && req_i[scan_idx]) begin
          winner = IDW'(scan_idx);
          found  = 1'b1;
        end
      end
    end
  end

  // The outstanding limit is checked against the registered count only.
  // A response popping in the same cycle does not free a slot until the next cycle.
  assign stall = (count_q == CW'(MAX_OUTSTANDING));
  assign hs    = slv_req_o && slv_gnt_i;
  assign pop   = slv_r_valid_i && (count_q != '0);

  always_comb begin
    slv_req_o   = (|req_i) && !stall;
    slv_add_o   = '0;
    slv_wen_o   = 1'b0;
    slv_wdata_o = '0;
    slv_be_o    = '0;
    gnt_o       = '0;
    r_valid_o   = '0;
    if (slv_req_o) begin
      slv_add_o   = add_i[winner*32 +: 32];
      slv_wen_o   = wen_i[winner];
      slv_wdata_o = wdata_i[winner*64 +: 64];
      slv_be_o    = be_i[winner*8 +: 8];
    end
    if (hs) gnt_o[winner] = 1'b1;
    if (pop) r_valid_o[fifo_q[head_q]] = 1'b1;
  end

  assign r_rdata_o = {NB_MASTERS{slv_r_rdata_i}};
  assign r_opc_o   = {NB_MASTERS{slv_r_opc_i}};
  assign err_o     = err_q;

  // Round-robin pointer and lock next state
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      rr_ptr_d = (winner == IDW'(NB_MASTERS - 1)) ? '0 : winner + 1'b1;
      lock_d   = LK_FREE;
    end else if (slv_req_o) begin
      lock_d     = LK_HELD;
      lock_idx_d = winner;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= LK_FREE;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Outstanding-ID FIFO and sticky error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      if (hs) begin
        fifo_q[tail_q] <= winner;
        tail_q         <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      case ({hs, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (slv_r_valid_i && (count_q == '0)) err_q <= 1'b1;
    end
  end

endmodule
